mac_array_drain: RTL
====================

Name: mac_array_drain

Overview:
- Output-side companion of the mac array: consumes the row-skewed accum_out_chained bus from the bottom row.
- Deskews the columns so each output vector (one 32-bit partial sum per output channel) is aligned in a single word.
- Buffers vectors in a small FIFO and hands them to the ofmap buffer over a valid/ready handshake.
- Counts vectors per tile, flags the last one, and backpressures the array controller.

Parameters:
- OC0, 4, array width (output channels per vector).
- FIFO_DEPTH, 4, output FIFO entries; must be >= 2 and a power of 2.
- ACC_W, 32, accumulator width per column.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  array advance enable, the same signal that drives the mac array. Deskew pipes shift only when en=1.
- start  in  1  one-cycle pulse; latches cfg_num_vec and begins a tile.
- cfg_num_vec  in  16  number of output vectors in this tile.
- in_valid  in  1  column-0 result valid on accum_out_chained this cycle. Column j's result for the same vector arrives j en-cycles later.
- accum_out_chained  in  ACC_W*OC0  bottom-row array output; column j occupies bits [ACC_W*(j+1)-1 : ACC_W*j].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  ACC_W*OC0  aligned vector, same column packing as the input.
- out_last  out  1  high with the final vector of the tile.
- array_stall  out  1  controller must hold en=0 while this is high.
- done  out  1  one-cycle pulse when the tile completes.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset: all deskew pipes, valid pipe, FIFO pointers/count, vector counter and FSM are cleared; FSM goes to IDLE.
  - out_valid=0, out_data=0, out_last=0, array_stall=0, done=0, overflow=0.
- Reset mid-tile discards all buffered and in-flight data; no done is produced.
- Deskew:
  - Column j passes through OC0-1-j registers that advance only when en=1. Column OC0-1 has zero stages.
  - in_valid passes through an OC0-1 stage valid pipe under the same enable.
  - vec_valid = valid pipe output, or in_valid itself when OC0=1.
- Push: on an edge with en=1, vec_valid=1, FSM=RUN.
  - In IDLE, vec_valid is ignored; no push.
- Pop: out_valid & out_ready.
- Latency: in_valid at en-cycle t, with en held high, gives out_valid in cycle t+OC0 (OC0-1 deskew cycles plus 1 FIFO write).
- FIFO:
  - out_valid = count!=0.
  - out_data = head entry, forced 0 when empty.
  - Simultaneous push and pop when full: allowed, count unchanged.
  - Simultaneous push and pop when empty: the pushed word appears next cycle; no bypass.
- array_stall = (count==FIFO_DEPTH) & ~out_ready, combinational.
- Overflow: a push with count==FIFO_DEPTH and no pop drops the word and sets overflow. Overflow clears only on rst.
- Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE: on start, latch cfg_num_vec into remaining.
    - If cfg_num_vec==0: go to DONE.
    - Otherwise: go to RUN.
  - RUN: each pop decrements remaining.
    - out_last = out_valid & (remaining==1).
    - The pop with remaining==1 transitions to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start while in RUN or DONE is ignored.
  - Pushes arriving after remaining vectors are satisfied are still buffered. The bench must not produce them; there is no error flag for this case.
- Widths: data is passed through unmodified, with no arithmetic on payload. remaining is 16 bits and never underflows.

Decomposition:
- Shared package mac_pkg: ACC_W default and the drain FSM state enum (IDLE, RUN, DONE).
- One natural sub-module: sync_fifo (parameterized width/depth, push/pop/full/empty/count), reusable for the ifmap feeder.
- Deskew pipes and FSM stay in mac_array_drain.

Test Plan:
- Reset/idle: rst high 2 cycles, then low, no stimulus -> all outputs 0; in_valid pulses while in IDLE produce no out_valid.
- Deskew, OC0=4, cfg_num_vec=1, out_ready=1, en=1:
  - Stimulus: in_valid at cycle 0; column j carries 0x100+j in cycle j.
  - Response: out_valid and out_last at cycle 4 with out_data={0x103,0x102,0x101,0x100}; done at cycle 5.
- Stream 8 vectors, en=1, out_ready=1 -> 8 consecutive beats in order, out_last only on beat 8, array_stall never high.
- Backpressure: out_ready=0, push 4 vectors to fill the FIFO (FIFO_DEPTH=4) -> array_stall=1.
  - Controller drops en; pipes hold; overflow stays 0.
  - Raise out_ready: all vectors drain in order, with no loss.
- Overflow: with FIFO full and out_ready=0, force en=1 with a valid vector -> overflow=1 sticky; FIFO contents unchanged.
- Zero-length tile plus mid-tile reset:
  - start with cfg_num_vec=0 -> done the next cycle, no out_valid.
  - Start a 4-vector tile, assert rst after 2 pops -> all outputs 0, no done.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the mac array blocks: accumulator width and drain FSM states.
package mac_pkg;

    localparam int ACC_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } drain_state_e;

endpackage

// File: rtl/mac_array_drain_if.sv
// Output stream from the drain to the ofmap buffer: aligned vector plus valid/ready and tile-last.
interface mac_array_drain_if
    import mac_pkg::*;
#(
    parameter int W = ACC_W_DEF * 4
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO: power-of-2 depth, wrapping pointers, head forced to zero when empty.
// A push while full is accepted only if the same edge pops; otherwise it is ignored.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);

    // Storage array: written on accepted pushes only, no reset needed on payload.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mac_array_drain.sv
// Output side of the mac array: deskews the bottom-row columns into aligned vectors,
// buffers them, counts vectors per tile and backpressures the array controller.
module mac_array_drain
    import mac_pkg::*;
#(
    parameter int OC0        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_W      = ACC_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [15:0]            cfg_num_vec,
    input  logic                   in_valid,
    input  logic [ACC_W*OC0-1:0]   accum_out_chained,
    mac_array_drain_if.master      out_if,
    output logic                   array_stall,
    output logic                   done,
    output logic                   overflow
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [OC0-1:0][ACC_W-1:0] w_cols_in;
    logic [OC0-1:0][ACC_W-1:0] w_cols_out;
    logic                      w_vec_valid;

    drain_state_e  r_state;
    drain_state_e  w_state_nxt;
    logic [15:0]   r_remaining;
    logic [15:0]   w_remaining_nxt;
    logic          r_overflow;
    logic          w_done;
    logic          w_last;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    assign w_cols_in = accum_out_chained;

    // Column j arrives j en-cycles after column 0, so it is delayed OC0-1-j stages
    // to line every column up with the last one.
    for (genvar j = 0; j < OC0; j++) begin : g_col
        localparam int ST = OC0 - 1 - j;
        if (ST == 0) begin : g_pass
            assign w_cols_out[j] = w_cols_in[j];
        end else begin : g_pipe
            logic [ST-1:0][ACC_W-1:0] r_sr;
            // Shift this column one stage per array advance.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sr <= '0;
                end else if (en) begin
                    r_sr[0] <= w_cols_in[j];
                    for (int s = 1; s < ST; s++) r_sr[s] <= r_sr[s-1];
                end
            end
            assign w_cols_out[j] = r_sr[ST-1];
        end
    end

    // Column-0 valid tracks the longest column delay so it marks the aligned vector.
    if (OC0 == 1) begin : g_vld_none
        assign w_vec_valid = in_valid;
    end else begin : g_vld
        logic [OC0-2:0] r_vld_pipe;
        // Valid shift register under the same enable as the data pipes.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld_pipe <= '0;
            end else if (en) begin
                r_vld_pipe[0] <= in_valid;
                for (int s = 1; s < OC0 - 1; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
            end
        end
        assign w_vec_valid = r_vld_pipe[OC0-2];
    end

    // Vectors are only captured while a tile is running; idle traffic is discarded.
    assign w_push = en & w_vec_valid & (r_state == RUN);
    assign w_pop  = out_if.out_valid & out_if.out_ready;
    assign w_drop = w_push & w_full & ~w_pop;

    sync_fifo #(
        .WIDTH (ACC_W * OC0),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_cols_out),
        .o_rdata (out_if.out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_if.out_valid = ~w_empty;
    assign out_if.out_last  = w_last;
    // Stall only when no slot frees up this cycle; a ready consumer keeps the array moving.
    assign array_stall      = (w_count == CW'(FIFO_DEPTH)) & ~out_if.out_ready;
    assign done             = w_done;
    assign overflow         = r_overflow;

    // Sticky overflow: a dropped vector is an unrecoverable error for this tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Tile FSM state and remaining-vector counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Next state, remaining count, last flag and done pulse.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_done          = 1'b0;
        w_last          = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_remaining_nxt = cfg_num_vec;
                    w_state_nxt     = (cfg_num_vec == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                w_last = out_if.out_valid & (r_remaining == 16'd1);
                if (w_pop) begin
                    if (r_remaining != 16'd0) w_remaining_nxt = r_remaining - 16'd1;
                    if (r_remaining == 16'd1) w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule
